fifo_bank_ctrl: RTL

Pointer and sequencing controller for the banked output FIFO: NUM_OF_MEM single-word memory banks are written one word per cycle in round-robin order. A window of NUM_OF_MEM consecutive words starting at any word offset is read out in one cycle. The block generates per-bank write enables and row addresses, staggered per-bank read row addresses, and the registered rotation select for the downstream output rotation mux. It owns fill level, full/window-valid status and variable-step pops.

---
 rtl/fifo_bank_pkg.sv | 45 ++++
 rtl/fifo_bank_ctrl_if.sv | 39 +++
 rtl/fifo_bank_raddr_gen.sv | 27 ++
 rtl/fifo_bank_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/fifo_bank_pkg.sv
// Shared constants and helpers for the banked output FIFO: controller, output mux and bank wrapper.
// Row/bank-index geometry is derived here so every consumer slices word pointers identically.
package fifo_bank_pkg;

  localparam int DEF_DATA_W          = 16;
  localparam int DEF_ADDR_W          = 11;
  localparam int DEF_NUM_OF_MEM      = 8;
  localparam int DEF_LOG2_NUM_OF_MEM = 3;

  function automatic int clog2(input int unsigned value);
    int unsigned rem;
    int          bits;
    rem  = (value > 0) ? value - 1 : 0;
    bits = 0;
    while (rem > 0) begin
      rem  = rem >> 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic int row_w(input int addr_w, input int log2_num_of_mem);
    return addr_w - log2_num_of_mem;
  endfunction

  // A word pointer splits into [row | bank index]; the bank index is the low field.
  localparam int DEF_ROW_W        = row_w(DEF_ADDR_W, DEF_LOG2_NUM_OF_MEM);
  localparam int DEF_BANK_IDX_LSB = 0;
  localparam int DEF_BANK_IDX_MSB = DEF_LOG2_NUM_OF_MEM - 1;
  localparam int DEF_ROW_LSB      = DEF_LOG2_NUM_OF_MEM;
  localparam int DEF_ROW_MSB      = DEF_ADDR_W - 1;

  typedef enum logic [1:0] {
    POP_IDLE   = 2'd0,
    POP_ACCEPT = 2'd1,
    POP_REJECT = 2'd2
  } pop_res_e;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_DROP   = 2'd2
  } wr_res_e;

endpackage

// File: rtl/fifo_bank_ctrl_if.sv
// Handshake/bank-address bundle between the FIFO client and the banked FIFO controller.
// The master side pushes and pops; the slave side is the controller.
interface fifo_bank_ctrl_if
  import fifo_bank_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int NUM_OF_MEM      = DEF_NUM_OF_MEM,
  parameter int LOG2_NUM_OF_MEM = DEF_LOG2_NUM_OF_MEM
);

  localparam int ROW_W = row_w(ADDR_W, LOG2_NUM_OF_MEM);

  logic                          flush_i;
  logic                          wr_en_i;
  logic                          full_o;
  logic                          ovf_o;
  logic [NUM_OF_MEM-1:0]         bank_we_o;
  logic [ROW_W-1:0]              bank_waddr_o;
  logic                          rd_en_i;
  logic [LOG2_NUM_OF_MEM:0]      rd_step_i;
  logic                          rd_err_o;
  logic [NUM_OF_MEM*ROW_W-1:0]   bank_raddr_o;
  logic [ADDR_W-1:0]             mux_addr_o;
  logic                          win_valid_o;
  logic [ADDR_W:0]               count_o;

  modport master (
    output flush_i, wr_en_i, rd_en_i, rd_step_i,
    input  full_o, ovf_o, bank_we_o, bank_waddr_o, rd_err_o,
           bank_raddr_o, mux_addr_o, win_valid_o, count_o
  );

  modport slave (
    input  flush_i, wr_en_i, rd_en_i, rd_step_i,
    output full_o, ovf_o, bank_we_o, bank_waddr_o, rd_err_o,
           bank_raddr_o, mux_addr_o, win_valid_o, count_o
  );

endinterface

// File: rtl/fifo_bank_raddr_gen.sv
// Per-bank read row generation for an NUM_OF_MEM-word window starting at an arbitrary word pointer.
// Banks below the window's starting bank hold the tail of the window, one row further on.
module fifo_bank_raddr_gen
  import fifo_bank_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int NUM_OF_MEM      = DEF_NUM_OF_MEM,
  parameter int LOG2_NUM_OF_MEM = DEF_LOG2_NUM_OF_MEM,
  localparam int ROW_W          = row_w(ADDR_W, LOG2_NUM_OF_MEM)
) (
  input  logic [ADDR_W-1:0]            rd_ptr_nxt_i,
  output logic [NUM_OF_MEM*ROW_W-1:0]  bank_raddr_o
);

  logic [LOG2_NUM_OF_MEM-1:0] start_bank;
  logic [ROW_W-1:0]           base_row;

  assign start_bank = rd_ptr_nxt_i[LOG2_NUM_OF_MEM-1:0];
  assign base_row   = rd_ptr_nxt_i[ADDR_W-1:LOG2_NUM_OF_MEM];

  for (genvar b = 0; b < NUM_OF_MEM; b++) begin : g_bank
    localparam logic [LOG2_NUM_OF_MEM-1:0] BANK_IDX = LOG2_NUM_OF_MEM'(b);
    // Row arithmetic wraps naturally at 2^ROW_W, matching the circular word pointer.
    assign bank_raddr_o[b*ROW_W +: ROW_W] = base_row + ROW_W'(BANK_IDX < start_bank);
  end

endmodule

// File: rtl/fifo_bank_ctrl.sv
// Pointer/sequencing controller for the banked output FIFO: round-robin bank writes,
// variable-step window pops, fill level and window-valid status for the output rotation mux.
module fifo_bank_ctrl
  import fifo_bank_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int NUM_OF_MEM      = DEF_NUM_OF_MEM,
  parameter int LOG2_NUM_OF_MEM = DEF_LOG2_NUM_OF_MEM
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  fifo_bank_ctrl_if.slave  bus
);

  localparam int ROW_W  = row_w(ADDR_W, LOG2_NUM_OF_MEM);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int STEP_W = LOG2_NUM_OF_MEM + 1;

  localparam logic [CNT_W-1:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  WIN_WORDS = CNT_W'(NUM_OF_MEM);
  localparam logic [STEP_W-1:0] MAX_STEP  = STEP_W'(NUM_OF_MEM);

  if (DATA_W < 1 || ADDR_W <= LOG2_NUM_OF_MEM || LOG2_NUM_OF_MEM < 1 ||
      LOG2_NUM_OF_MEM != clog2(NUM_OF_MEM) || (1 << LOG2_NUM_OF_MEM) != NUM_OF_MEM) begin : g_bad_params
    $error("fifo_bank_ctrl: NUM_OF_MEM must equal 2**LOG2_NUM_OF_MEM and be narrower than the pointer");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              win_valid_q, win_valid_d;

  logic              live;
  logic              full;
  logic              step_ok;
  wr_res_e           wr_res;
  pop_res_e          pop_res;
  logic              wr_acc;
  logic              pop_acc;
  logic [STEP_W-1:0] popped;

  // Classify this cycle's push and pop requests against the registered state only.
  always_comb begin
    live    = rst_n_i && !bus.flush_i;
    full    = (count_q == DEPTH);
    step_ok = (bus.rd_step_i <= MAX_STEP);
    wr_res  = WR_IDLE;
    pop_res = POP_IDLE;
    if (live && bus.wr_en_i) begin
      wr_res = full ? WR_DROP : WR_ACCEPT;
    end
    if (live && bus.rd_en_i) begin
      pop_res = (win_valid_q && step_ok) ? POP_ACCEPT : POP_REJECT;
    end
    wr_acc  = (wr_res == WR_ACCEPT);
    pop_acc = (pop_res == POP_ACCEPT);
    popped  = pop_acc ? bus.rd_step_i : '0;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(popped);
    count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(popped);
    // This cycle's write is excluded: its word is not yet readable from a synchronous bank.
    win_valid_d = (count_q - CNT_W'(popped)) >= WIN_WORDS;
    if (bus.flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign bus.full_o       = full;
  assign bus.ovf_o        = (wr_res == WR_DROP);
  assign bus.rd_err_o     = (pop_res == POP_REJECT);
  assign bus.bank_we_o    = wr_acc ? (NUM_OF_MEM'(1) << wr_ptr_q[LOG2_NUM_OF_MEM-1:0]) : '0;
  assign bus.bank_waddr_o = wr_ptr_q[ADDR_W-1:LOG2_NUM_OF_MEM];
  assign bus.mux_addr_o   = rd_ptr_q;
  assign bus.win_valid_o  = win_valid_q;
  assign bus.count_o      = count_q;

  // Read rows follow the post-pop pointer so bank data lines up with mux_addr_o next cycle.
  fifo_bank_raddr_gen #(
    .ADDR_W          (ADDR_W),
    .NUM_OF_MEM      (NUM_OF_MEM),
    .LOG2_NUM_OF_MEM (LOG2_NUM_OF_MEM)
  ) u_raddr_gen (
    .rd_ptr_nxt_i (rd_ptr_d),
    .bank_raddr_o (bus.bank_raddr_o)
  );

endmodule
